key_recorder: RTL and testbench

- Record/playback stage directly upstream of the buzzer tone generator.
- Captures free-play key presses as timed note events in an on-chip buffer, then replays them as a note/octave stream.
- note_out/octave_out carry the same note code and octave encoding the buzzer already consumes (0 = rest, 1..7 = do..si).
- Sits beside the controller; the top-level mux selects this block's outputs when replay is active.

---
 rtl/key_recorder_if.sv | 29 ++
 rtl/key_recorder.sv | 216 +++++++++++++++++++++
 tb/tb_key_recorder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/key_recorder_if.sv
// Bundle of the key_recorder's data and status signals.
// master = the block driving keys/buttons, slave = key_recorder itself.
interface key_recorder_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [6:0]    keys;
  logic [1:0]    octave;
  logic          write_on;
  logic          play_start;
  logic [3:0]    note_out;
  logic [1:0]    octave_out;
  logic          playing;
  logic          recording;
  logic [CW-1:0] rec_count;
  logic          full;
  logic          done;

  modport master (
    output keys, octave, write_on, play_start,
    input  note_out, octave_out, playing, recording, rec_count, full, done
  );

  modport slave (
    input  keys, octave, write_on, play_start,
    output note_out, octave_out, playing, recording, rec_count, full, done
  );
endinterface

// File: rtl/key_recorder.sv
// key_recorder: records free-play key presses as timed note events
// {note, octave, dur} and replays them as a note/octave stream for the buzzer.
// Optional build macro LOOP_PLAYBACK_EN: replay wraps to entry 0 after the
// last entry (done pulses once per wrap) until play_start or reset.
//
// state | meaning
// IDLE  | outputs 0, waiting for write_on / play_start rising edge
// REC   | live note passed through, events committed to the buffer
// PLAY  | buffer entries replayed, each held for its tick count
module key_recorder #(
  parameter int TICK_DIV = 1_000_000,
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  key_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 4 + 2 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [DUR_W-1:0] DUR_PRE    = DUR_MAX - DUR_W'(1);
  localparam logic [TW-1:0]    TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(DEPTH - 1);
`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic             write_q, play_q;
  logic             write_rise, write_fall, play_rise;
  logic [3:0]       live_note;
  logic             live_change;
  logic [3:0]       cur_note;
  logic [1:0]       cur_oct;
  logic [DUR_W-1:0] cur_dur;
  logic [CW-1:0]    rec_count;
  logic             full, done;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic [AW-1:0]    rd_ptr;
  logic [DUR_W-1:0] dur_left;
  logic             load_pend;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_entry;
  logic             wr_en;
  logic [EW-1:0]    wr_data;
  logic             commit_fill;
  logic             play_expire, play_last, play_end;

  // Live note: lowest pressed key wins, no key is a rest.
  always_comb begin
    live_note = 4'd0;
    for (int i = 6; i >= 0; i--)
      if (bus.keys[i]) live_note = 4'(i + 1);
  end

  assign tick        = (tick_cnt == TICK_LAST);
  assign write_rise  = bus.write_on & ~write_q;
  assign write_fall  = ~bus.write_on & write_q;
  assign play_rise   = bus.play_start & ~play_q;
  assign live_change = (live_note != cur_note) || (bus.octave != cur_oct);
  assign rd_entry    = mem[rd_ptr];
  assign play_last   = ({1'b0, rd_ptr} == (rec_count - CW'(1)));
  assign play_expire = (state_q == PLAY) && !load_pend && tick &&
                       (dur_left <= DUR_W'(1));
  assign commit_fill = wr_en && (rec_count == COUNT_LAST);

  // Next state and commit decisions.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_data  = {cur_note, cur_oct, cur_dur};
    play_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_rise) state_d = REC;
        else if (play_rise && rec_count != '0) state_d = PLAY;
      end
      REC: begin
        if (write_fall) begin
          wr_en   = (cur_dur != '0);
          state_d = IDLE;
        end else if (live_change) begin
          // a change before the first tick just replaces the event
          wr_en = (cur_dur != '0);
        end else if (tick && cur_dur == DUR_PRE) begin
          wr_en   = 1'b1;
          wr_data = {cur_note, cur_oct, DUR_MAX};
        end
        if (wr_en && rec_count == COUNT_LAST) state_d = IDLE;
      end
      PLAY: begin
        if (play_rise) begin
          state_d = IDLE;
        end else if (play_expire && play_last) begin
          play_end = 1'b1;
          if (!LOOP_EN) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Duration tick prescaler, restarted on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           tick_cnt <= '0;
    else if (state_d != state_q || tick) tick_cnt <= '0;
    else                                 tick_cnt <= tick_cnt + TW'(1);
  end

  // Event buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[rec_count[AW-1:0]] <= wr_data;
  end

  // Recording/replay datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q   <= 1'b0;
      play_q    <= 1'b0;
      rec_count <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      note_q    <= '0;
      oct_q     <= '0;
      cur_note  <= '0;
      cur_oct   <= '0;
      cur_dur   <= '0;
      rd_ptr    <= '0;
      dur_left  <= '0;
      load_pend <= 1'b0;
    end else begin
      write_q <= bus.write_on;
      play_q  <= bus.play_start;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          note_q <= '0;
          oct_q  <= '0;
          if (state_d == REC) begin
            rec_count <= '0;
            full      <= 1'b0;
            cur_note  <= live_note;
            cur_oct   <= bus.octave;
            cur_dur   <= '0;
          end else if (state_d == PLAY) begin
            rd_ptr    <= '0;
            load_pend <= 1'b1;
          end
        end
        REC: begin
          note_q <= live_note;
          oct_q  <= bus.octave;
          if (wr_en)       rec_count <= rec_count + CW'(1);
          if (commit_fill) full <= 1'b1;
          if (live_change) begin
            cur_note <= live_note;
            cur_oct  <= bus.octave;
            cur_dur  <= '0;
          end else if (tick) begin
            cur_dur <= (cur_dur == DUR_PRE) ? '0 : cur_dur + DUR_W'(1);
          end
          if (state_d == IDLE) begin
            note_q <= '0;
            oct_q  <= '0;
          end
        end
        PLAY: begin
          if (state_d == IDLE) begin
            note_q    <= '0;
            oct_q     <= '0;
            load_pend <= 1'b0;
            done      <= play_end;
          end else if (load_pend) begin
            {note_q, oct_q, dur_left} <= rd_entry;
            load_pend <= 1'b0;
          end else if (play_expire) begin
            load_pend <= 1'b1;
            if (play_last) begin
              rd_ptr <= '0;
              done   <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end else if (tick) begin
            dur_left <= dur_left - DUR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.note_out   = note_q;
  assign bus.octave_out = oct_q;
  assign bus.playing    = (state_q == PLAY);
  assign bus.recording  = (state_q == REC);
  assign bus.rec_count  = rec_count;
  assign bus.full       = full;
  assign bus.done       = done;
endmodule

// File: tb/tb_key_recorder.sv
// Directed bench for key_recorder with TICK_DIV=4, DEPTH=4, DUR_W=8.
// Inputs are changed and outputs sampled on the falling edge; cyc counts
// rising edges, so an input set at cyc==N is seen by rising edge N+1.
module tb_key_recorder;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int DUR_W    = 8;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   t0;
  int   dc;

  key_recorder_if #(.DEPTH(DEPTH)) bus ();

  key_recorder #(
    .TICK_DIV(TICK_DIV),
    .DEPTH   (DEPTH),
    .DUR_W   (DUR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  initial begin
    bus.keys       = '0;
    bus.octave     = '0;
    bus.write_on   = 1'b0;
    bus.play_start = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_playing",   bus.playing,    0);
    check("rst_recording", bus.recording,  0);
    check("rst_note",      bus.note_out,   0);
    check("rst_octave",    bus.octave_out, 0);
    check("rst_count",     bus.rec_count,  0);
    check("rst_full",      bus.full,       0);
    check("rst_done",      bus.done,       0);
    reset = 1'b0;

    // play_start with an empty buffer
    at(cyc + 2); t0 = cyc;
    bus.play_start = 1'b1;
    at(t0 + 3);
    check("empty_playing", bus.playing, 0);
    check("empty_done",    done_cnt,    0);
    bus.play_start = 1'b0;

    // session closed before the first tick commits nothing
    at(cyc + 2); t0 = cyc;
    bus.keys = 7'd1; bus.write_on = 1'b1;
    at(t0 + 1);
    check("zdur_recording", bus.recording, 1);
    bus.write_on = 1'b0;
    at(t0 + 2);
    check("zdur_idle",  bus.recording, 0);
    check("zdur_count", bus.rec_count, 0);

    // key change at dur==0 overwrites: note1 -> note2, then 2 ticks
    at(cyc + 2); t0 = cyc;
    bus.keys = 7'd1; bus.octave = 2'd0; bus.write_on = 1'b1;
    at(t0 + 1);  bus.keys = 7'd2;
    at(t0 + 9);  bus.write_on = 1'b0;
    at(t0 + 10);
    check("glitch_count", bus.rec_count, 1);
    at(t0 + 12); t0 = cyc;
    bus.play_start = 1'b1;
    at(t0 + 2);  check("glitch_play_note", bus.note_out, 2);
    at(t0 + 8);  check("glitch_play_hold", bus.playing,  1);
    at(t0 + 9);  check("glitch_play_done", bus.done,     1);
    bus.play_start = 1'b0;

    // note 3 for 12 ticks, rest for 5, note 1 / octave 2 for 3
    at(cyc + 2); t0 = cyc;
    bus.keys = 7'd4; bus.octave = 2'd1; bus.write_on = 1'b1;
    at(t0 + 2);
    check("rec_recording", bus.recording,  1);
    check("rec_live_note", bus.note_out,   3);
    check("rec_live_oct",  bus.octave_out, 1);
    at(t0 + 50); bus.keys = 7'd0;
    at(t0 + 70); bus.keys = 7'd1; bus.octave = 2'd2;
    at(t0 + 82); bus.write_on = 1'b0;
    at(t0 + 83);
    check("rec3_count", bus.rec_count, 3);
    check("rec3_idle",  bus.recording, 0);
    check("rec3_note0", bus.note_out,  0);
    check("rec3_full",  bus.full,      0);

    // replay the three entries
    at(cyc + 2); t0 = cyc; dc = done_cnt;
    bus.play_start = 1'b1;
    at(t0 + 1);  check("p3_playing",   bus.playing,    1);
                 check("p3_preload",   bus.note_out,   0);
    at(t0 + 2);  check("p3_e0_note",   bus.note_out,   3);
                 check("p3_e0_oct",    bus.octave_out, 1);
    at(t0 + 49); check("p3_e0_last",   bus.note_out,   3);
    at(t0 + 50); check("p3_e1_note",   bus.note_out,   0);
                 check("p3_e1_oct",    bus.octave_out, 1);
    at(t0 + 69); check("p3_e1_last",   bus.playing,    1);
                 check("p3_e1_note_l", bus.note_out,   0);
    at(t0 + 70); check("p3_e2_note",   bus.note_out,   1);
                 check("p3_e2_oct",    bus.octave_out, 2);
    at(t0 + 80); check("p3_e2_last",   bus.note_out,   1);
                 check("p3_done_early", bus.done,      0);
    at(t0 + 81); check("p3_done",      bus.done,       1);
                 check("p3_end_play",  bus.playing,    0);
                 check("p3_end_note",  bus.note_out,   0);
                 check("p3_end_oct",   bus.octave_out, 0);
    at(t0 + 83); check("p3_done_once", done_cnt - dc,  1);
    bus.play_start = 1'b0;

    // hold note 7 for 257 ticks -> entries of 255 and 2 ticks
    at(cyc + 2); t0 = cyc;
    bus.keys = 7'd64; bus.octave = 2'd3; bus.write_on = 1'b1;
    at(t0 + 1030); bus.write_on = 1'b0;
    at(t0 + 1031);
    check("sat_count", bus.rec_count, 2);
    at(cyc + 2); t0 = cyc;
    bus.play_start = 1'b1;
    at(t0 + 2);    check("sat_note",    bus.note_out,   7);
                   check("sat_oct",     bus.octave_out, 3);
    at(t0 + 1028); check("sat_hold",    bus.playing,    1);
                   check("sat_hold_n",  bus.note_out,   7);
    at(t0 + 1029); check("sat_done",    bus.done,       1);
                   check("sat_end",     bus.playing,    0);
    bus.play_start = 1'b0;

    // both edges together: write_on wins; then fill the 4-entry buffer
    at(cyc + 2); t0 = cyc;
    bus.keys = 7'd1; bus.octave = 2'd0; bus.write_on = 1'b1; bus.play_start = 1'b1;
    at(t0 + 1);
    check("prio_recording", bus.recording, 1);
    check("prio_playing",   bus.playing,   0);
    check("prio_count",     bus.rec_count, 0);
    at(t0 + 9);  bus.keys = 7'd2;
    at(t0 + 17); bus.keys = 7'd1;
    at(t0 + 25); bus.keys = 7'd2;
    at(t0 + 33);
    check("fill_count3", bus.rec_count, 3);
    check("fill_rec",    bus.recording, 1);
    bus.keys = 7'd1;
    at(t0 + 34);
    check("full_flag",  bus.full,      1);
    check("full_count", bus.rec_count, 4);
    check("full_idle",  bus.recording, 0);
    check("full_note",  bus.note_out,  0);
    at(t0 + 36);
    check("full_stay_idle", bus.recording, 0);
    bus.write_on = 1'b0; bus.play_start = 1'b0;

    // asynchronous reset in the middle of replay
    at(cyc + 2); t0 = cyc;
    bus.play_start = 1'b1;
    at(t0 + 10);
    check("mid_playing", bus.playing,  1);
    check("mid_note",    bus.note_out, 2);
    #2 reset = 1'b1;
    #1;
    check("arst_playing", bus.playing,    0);
    check("arst_note",    bus.note_out,   0);
    check("arst_oct",     bus.octave_out, 0);
    check("arst_count",   bus.rec_count,  0);
    check("arst_full",    bus.full,       0);
    @(negedge clk);
    reset = 1'b0; bus.play_start = 1'b0;
    @(negedge clk);
    bus.play_start = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_play", bus.playing, 0);
    bus.play_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
